// File: rtl/tenyr_bus_pkg.sv
// Shared definitions for the tenyr bus responder: MMIO register offsets,
// the illegal-opcode fill word and the console transmitter state encoding.
package tenyr_bus_pkg;

  localparam logic [1:0] MMIO_CYCLE   = 2'd0;
  localparam logic [1:0] MMIO_CONSOLE = 2'd1;
  localparam logic [1:0] MMIO_STATUS  = 2'd2;
  localparam logic [1:0] MMIO_HALT    = 2'd3;

  // Returned for any fetch outside RAM so a runaway core decodes an illegal op.
  localparam logic [31:0] ILLEGAL_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tenyr_console_tx.sv
// Console transmitter: accepts one byte, pulses the strobe for one clock,
// then stays busy for TX_CYCLES clocks. Bytes offered while busy are
// dropped and counted (saturating at 255).
module tenyr_console_tx
  import tenyr_bus_pkg::*;
#(
  parameter int TX_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_i,
  input  logic [7:0] byte_i,
  output logic [7:0] tx_data_o,
  output logic       tx_strobe_o,
  output logic       busy_o,
  output logic [7:0] drop_cnt_o
);

  localparam int CNT_W = (TX_CYCLES > 1) ? $clog2(TX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       tx_data_q;
  logic [7:0]       drop_q;
  logic             strobe_q;

  // Console FSM with registered strobe/data; a write on the final busy cycle is still a drop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      drop_q    <= 8'h00;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (wr_i) begin
            state_q   <= TX_BUSY;
            cnt_q     <= CNT_LOAD;
            strobe_q  <= 1'b1;
            tx_data_q <= byte_i;
          end
        end
        TX_BUSY: begin
          if (wr_i) begin
            drop_q <= sat_inc8(drop_q);
          end
          if (cnt_q == '0) begin
            state_q <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_strobe_o = strobe_q;
  assign busy_o      = (state_q == TX_BUSY);
  assign drop_cnt_o  = drop_q;

endmodule

// File: rtl/tenyr_mem_responder.sv
// Target end of the tenyr core buses: word-addressed RAM with a fetch port
// and a data read/write port, plus four MMIO registers (cycle counter,
// console, status, halt). Unmapped fetches return the illegal-opcode word.
// Optional build macro TENYR_RESP_WRPROT_EN: RAM writes below PROT_TOP are
// suppressed and raise the sticky wr_err flag; without it wr_err is 0.
module tenyr_mem_responder
  import tenyr_bus_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000,
  parameter int          TX_CYCLES = 16,
  parameter logic [31:0] PROT_TOP  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] insn_addr,
  output logic [31:0] insn_data,
  input  logic        rw,
  input  logic [31:0] norm_addr,
  inout  wire  [31:0] norm_data,
  output logic [7:0]  tx_data,
  output logic        tx_strobe,
  output logic        halt_req,
  output logic        wr_err
);

  localparam logic [31:0] RAM_WORDS = 32'd1 << ADDR_W;
`ifdef TENYR_RESP_WRPROT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  logic [31:0]       mem [RAM_WORDS];
  logic [31:0]       f_off, d_off, m_off;
  logic              f_ram_hit, d_ram_hit, d_mmio_hit;
  logic [ADDR_W-1:0] f_idx, d_idx;
  logic [1:0]        m_reg;
  logic [31:0]       wdata;
  logic              wr_ram, wr_prot, ram_we, mmio_we;
  logic [31:0]       insn_q, rdata_q, cycle_q, mmio_rdata;
  logic              rd_drv_q, halt_q;
  logic              con_busy;
  logic [7:0]        con_drops;

  // Unsigned offset compare catches both below-base and past-top addresses.
  assign f_off      = insn_addr - RAM_BASE;
  assign d_off      = norm_addr - RAM_BASE;
  assign m_off      = norm_addr - MMIO_BASE;
  assign f_ram_hit  = (f_off < RAM_WORDS);
  assign d_ram_hit  = (d_off < RAM_WORDS);
  assign d_mmio_hit = (m_off < 32'd4);
  assign f_idx      = f_off[ADDR_W-1:0];
  assign d_idx      = d_off[ADDR_W-1:0];
  assign m_reg      = m_off[1:0];

  assign wdata   = norm_data;
  assign wr_ram  = reset_n && rw && d_ram_hit;
  assign wr_prot = PROT_EN && (norm_addr < PROT_TOP);
  assign ram_we  = wr_ram && !wr_prot;
  assign mmio_we = reset_n && rw && d_mmio_hit;

  // RAM read/write port: write side.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[d_idx] <= wdata;
    end
  end

  // Fetch port with write-first forwarding from the data port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      insn_q <= 32'h0;
    end else if (!f_ram_hit) begin
      insn_q <= ILLEGAL_WORD;
    end else if (ram_we && (d_idx == f_idx)) begin
      insn_q <= wdata;
    end else begin
      insn_q <= mem[f_idx];
    end
  end

  // MMIO read mux; write-only and reserved bits read as zero.
  always_comb begin
    mmio_rdata = 32'h0;
    case (m_reg)
      MMIO_CYCLE:   mmio_rdata = cycle_q;
      MMIO_CONSOLE: mmio_rdata = 32'h0;
      MMIO_STATUS:  mmio_rdata = {16'h0, con_drops, 7'h0, con_busy};
      MMIO_HALT:    mmio_rdata = {31'h0, halt_q};
      default:      mmio_rdata = 32'h0;
    endcase
  end

  // Data read register; the bus is driven the next cycle only for a hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q  <= 32'h0;
      rd_drv_q <= 1'b0;
    end else begin
      rd_drv_q <= !rw && (d_ram_hit || d_mmio_hit);
      if (!rw) begin
        rdata_q <= d_ram_hit ? mem[d_idx] : mmio_rdata;
      end
    end
  end

  // Release the bus as soon as the core turns it around for a write.
  assign norm_data = (rd_drv_q && !rw) ? rdata_q : 32'bz;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_q <= 32'h0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // Sticky halt request on any nonzero write to the halt register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      halt_q <= 1'b0;
    end else if (mmio_we && (m_reg == MMIO_HALT) && (wdata != 32'h0)) begin
      halt_q <= 1'b1;
    end
  end

`ifdef TENYR_RESP_WRPROT_EN
  logic wr_err_q;

  // Sticky flag for RAM writes that hit the protected low region.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_err_q <= 1'b0;
    end else if (wr_ram && wr_prot) begin
      wr_err_q <= 1'b1;
    end
  end

  assign wr_err = wr_err_q;
`else
  assign wr_err = 1'b0;
`endif

  tenyr_console_tx #(
    .TX_CYCLES (TX_CYCLES)
  ) u_console (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_i        (mmio_we && (m_reg == MMIO_CONSOLE)),
    .byte_i      (wdata[7:0]),
    .tx_data_o   (tx_data),
    .tx_strobe_o (tx_strobe),
    .busy_o      (con_busy),
    .drop_cnt_o  (con_drops)
  );

  assign insn_data = insn_q;
  assign halt_req  = halt_q;

endmodule
